// File: rtl/aes_pkg.sv
// Shared constants, S-box/rcon lookups and FSM state type for the AES-128
// add-round-key stage and its on-chip key schedule.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [BYTE_W-1:0] rcon(input logic [ROUND_W-1:0] idx);
    logic [BYTE_W-1:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_add_round_key_stage_if.sv
// Key-load, input-state and output-state signals of the add-round-key stage.
interface aes_add_round_key_stage_if;
  import aes_pkg::*;

  logic               key_load;
  logic [DATA_W-1:0]  key_in;
  logic               key_ready;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [ROUND_W-1:0] in_round;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_err;

  modport master (
    output key_load, key_in, in_valid, in_data, in_round,
    input  key_ready, in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  key_load, key_in, in_valid, in_data, in_round,
    output key_ready, in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: derives round key i from round key i-1.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [DATA_W-1:0] prev_key,
  input  logic [BYTE_W-1:0] rcon_byte,
  output logic [DATA_W-1:0] next_key
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot, sub, t;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  // RotWord then SubWord on the last word, then fold in rcon.
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign t   = sub ^ {rcon_byte, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_add_round_key_stage.sv
// AES-128 add-round-key stage with an iterative on-chip key schedule that
// fills an 11-entry round-key file one key per cycle.
module aes_add_round_key_stage
  import aes_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  aes_add_round_key_stage_if.slave bus
);

  localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;

  state_t             state, state_next;
  logic [ROUND_W-1:0] cnt, cnt_next;
  logic [DATA_W-1:0]  rk [NUM_KEYS];
  logic               key_ready_q, key_ready_next;
  logic               load_rk0, expand_we;

  logic               out_valid_q, out_err_q;
  logic [DATA_W-1:0]  out_data_q;

  logic               accept, round_ok;
  logic [DATA_W-1:0]  prev_key, step_key, sel_key;
  logic [BYTE_W-1:0]  rcon_cur;

  assign accept   = bus.in_valid && key_ready_q;
  assign round_ok = (bus.in_round <= ROUND_W'(NUM_ROUNDS));
  assign rcon_cur = rcon(cnt);

  // State, counter and key_ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_ready_q <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      key_ready_q <= key_ready_next;
    end
  end

  // Next-state logic; a key_load in any state restarts the schedule.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_rk0   = 1'b0;
    expand_we  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.key_load) begin
          load_rk0   = 1'b1;
          cnt_next   = ROUND_W'(1);
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (bus.key_load) begin
          load_rk0 = 1'b1;
          cnt_next = ROUND_W'(1);
        end else begin
          expand_we = 1'b1;
          cnt_next  = cnt + ROUND_W'(1);
          if (cnt == ROUND_W'(NUM_ROUNDS)) begin
            state_next = READY;
          end
        end
      end
      READY: begin
        if (bus.key_load) begin
          load_rk0   = 1'b1;
          cnt_next   = ROUND_W'(1);
          state_next = EXPAND;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    key_ready_next = (state_next == READY);
  end

  // Read ports: previous key for the expansion step, selected key for data.
  always_comb begin
    prev_key = '0;
    sel_key  = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (cnt == ROUND_W'(i + 1)) prev_key = rk[i];
      if (bus.in_round == ROUND_W'(i)) sel_key = rk[i];
    end
  end

  aes_key_expand_step u_expand (
    .prev_key  (prev_key),
    .rcon_byte (rcon_cur),
    .next_key  (step_key)
  );

  // Round-key file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        rk[i] <= '0;
      end
    end else begin
      if (load_rk0) begin
        rk[0] <= bus.key_in;
      end
      for (int unsigned i = 1; i < NUM_KEYS; i++) begin
        if (expand_we && (cnt == ROUND_W'(i))) begin
          rk[i] <= step_key;
        end
      end
    end
  end

  // Output register; out-of-range rounds pass data through and flag an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= accept;
      out_err_q   <= accept && !round_ok;
      if (accept) begin
        out_data_q <= round_ok ? (bus.in_data ^ sel_key) : bus.in_data;
      end
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.in_ready  = key_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// Directed-vector bench for the AES-128 add-round-key stage using FIPS-197
// key schedules.
module tb_aes_add_round_key_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [127:0] A_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_add_round_key_stage_if bus();

  aes_add_round_key_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input int j);
    logic [31:0] w;
    w = 32'h9e3779b9 * 32'(j + 1);
    return {w, ~w, w ^ 32'h5a5a5a5a, 32'(j)};
  endfunction

  task automatic idle_inputs();
    bus.key_load = 1'b0;
    bus.key_in   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_round = '0;
  endtask

  // Called just after the edge that sampled key_load.
  task automatic wait_key_latency(input string tag);
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (bus.key_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early: key_ready=%b want 0 at cycle %0d", tag, bus.key_ready, k);
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.key_ready !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: key_ready=%b in_ready=%b want 1/1", tag, bus.key_ready, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.key_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: key_ready=%b in_ready=%b want 0/0", bus.key_ready, bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: out_valid=%b out_err=%b want 0/0", bus.out_valid, bus.out_err);
    end
    n_checks++;
    if (bus.out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h want 0", bus.out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_key_ignored();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = pat(99);
    bus.in_round = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL nokey_ignored: out_valid=%b want 0 at cycle %0d", bus.out_valid, k);
      end
    end
    idle_inputs();
  endtask

  task automatic test_key_latency();
    @(negedge clk);
    bus.key_load = 1'b1;
    bus.key_in   = KEY_A;
    @(negedge clk);
    bus.key_load = 1'b0;
    wait_key_latency("latency_a");
  endtask

  task automatic test_fips_round0();
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h3243f6a8885a308d313198a2e0370734;
    bus.in_round = 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b0 ||
        bus.out_data !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      n_fail++;
      $display("FAIL fips_round0: valid=%b err=%b data=%h want 1/0/193de3bea0f4e22b9ac68d2ae9f84808",
               bus.out_valid, bus.out_err, bus.out_data);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
      n_fail++;
      $display("FAIL hold_after_idle: valid=%b data=%h want 0/193de3bea0f4e22b9ac68d2ae9f84808",
               bus.out_valid, bus.out_data);
    end
  endtask

  // Rounds 0..10 then an out-of-range round 12 on consecutive cycles.
  task automatic test_back_to_back();
    logic [127:0] exp_data;
    logic         exp_err;
    for (int j = 0; j <= 12; j++) begin
      if (j >= 1) begin
        if (j - 1 <= 10) begin
          exp_data = pat(j - 1) ^ A_RK[j - 1];
          exp_err  = 1'b0;
        end else begin
          exp_data = pat(j - 1);
          exp_err  = 1'b1;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== exp_err || bus.out_data !== exp_data) begin
          n_fail++;
          $display("FAIL b2b_entry%0d: valid=%b err=%b data=%h want 1/%b/%h",
                   j - 1, bus.out_valid, bus.out_err, bus.out_data, exp_err, exp_data);
        end
      end
      if (j < 12) begin
        bus.in_valid = 1'b1;
        bus.in_data  = pat(j);
        bus.in_round = (j <= 10) ? 4'(j) : 4'd12;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: valid=%b err=%b want 0/0", bus.out_valid, bus.out_err);
    end
  endtask

  task automatic test_restart();
    bus.key_load = 1'b1;
    bus.key_in   = KEY_A;
    @(negedge clk);
    bus.key_load = 1'b0;
    repeat (4) @(negedge clk);
    bus.key_load = 1'b1;
    bus.key_in   = KEY_B;
    @(negedge clk);
    bus.key_load = 1'b0;
    wait_key_latency("restart");
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    bus.in_round = 4'd0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== KEY_B) begin
      n_fail++;
      $display("FAIL restart_rk0: valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, KEY_B);
    end
    bus.in_round = 4'd10;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== B_RK10) begin
      n_fail++;
      $display("FAIL restart_rk10: valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, B_RK10);
    end
  endtask

  // key_load coinciding with a transfer: old key used, then upstream holds.
  task automatic test_load_with_transfer();
    logic [127:0] x;
    x = pat(40);
    bus.key_load = 1'b1;
    bus.key_in   = KEY_A;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_round = 4'd10;
    @(negedge clk);
    bus.key_load = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== (x ^ B_RK10) || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_old_key: valid=%b data=%h in_ready=%b want 1/%h/0",
               bus.out_valid, bus.out_data, bus.in_ready, x ^ B_RK10);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL coincident_ignored: out_valid=%b want 0 at cycle %0d", bus.out_valid, k);
      end
    end
    n_checks++;
    if (bus.key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL coincident_reready: key_ready=%b want 1", bus.key_ready);
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== (x ^ A_RK[10])) begin
      n_fail++;
      $display("FAIL coincident_new_key: valid=%b data=%h want 1/%h",
               bus.out_valid, bus.out_data, x ^ A_RK[10]);
    end
  endtask

  task automatic test_reset_mid_expand();
    bus.key_load = 1'b1;
    bus.key_in   = KEY_B;
    bus.in_valid = 1'b1;
    bus.in_data  = pat(7);
    bus.in_round = 4'd1;
    @(posedge clk);
    #2;
    idle_inputs();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== (pat(7) ^ A_RK[1])) begin
      n_fail++;
      $display("FAIL pre_reset_xfer: valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, pat(7) ^ A_RK[1]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.key_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_err !== 1'b0 || bus.out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL async_reset: key_ready=%b valid=%b err=%b data=%h want 0/0/0/0",
               bus.key_ready, bus.out_valid, bus.out_err, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = pat(8);
    bus.in_round = 4'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.key_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_ignored: valid=%b key_ready=%b want 0/0 at cycle %0d",
                 bus.out_valid, bus.key_ready, k);
      end
    end
    idle_inputs();
    bus.key_load = 1'b1;
    bus.key_in   = KEY_B;
    @(negedge clk);
    bus.key_load = 1'b0;
    wait_key_latency("reload");
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    bus.in_round = 4'd10;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== B_RK10) begin
      n_fail++;
      $display("FAIL reload_rk10: valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, B_RK10);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_no_key_ignored();
    test_key_latency();
    test_fips_round0();
    test_back_to_back();
    test_restart();
    test_load_with_transfer();
    test_reset_mid_expand();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_add_round_key_stage.md
Name: aes_add_round_key_stage

Overview:
- Stage directly downstream of the MixColumns block in the AES-128 round datapath.
- Holds an on-chip iterative key schedule: loads a 128-bit cipher key, expands round keys 0..10 into a register file, one per cycle.
- XORs each incoming 128-bit state with the round key selected by the accompanying round index.
- Output is registered and feeds the next round's SubBytes input or the ciphertext register.

Parameters:
- NUM_ROUNDS, 10, last round-key index; fixed at 10 for AES-128, other values unsupported.
- DATA_W, 128, state and key width; fixed at 128.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_load  in  1  single-cycle pulse; capture key_in and start expansion
- key_in  in  128  cipher key, byte 0 at bits [127:120]
- key_ready  out  1  high when all 11 round keys are valid
- in_valid  in  1  in_data/in_round valid this cycle
- in_ready  out  1  stage accepts data; equals key_ready
- in_data  in  128  state from MixColumns (or ShiftRows for final round)
- in_round  in  4  round-key index 0..10
- out_valid  out  1  out_data valid, 1-cycle pulse per accepted input
- out_data  out  128  in_data XOR rk[in_round]
- out_err  out  1  accompanies out_valid; in_round exceeded NUM_ROUNDS

Behaviour:
- Reset (async assert, sync-deassert handled at top level):
  - state = IDLE; key_ready, out_valid, out_err = 0; out_data = 0.
  - Round-key file cleared to 0; round counter = 0.
- FSM states:
  - IDLE: key_ready = 0. key_load -> LOAD path: capture key_in into rk[0], counter = 1, go to EXPAND.
  - EXPAND: each cycle rk[counter] = expand_step(rk[counter-1], rcon[counter]); counter++. On the edge writing rk[10], go to READY.
  - READY: key_ready = 1. key_load -> capture new key into rk[0], counter = 1, go to EXPAND.
- key_load in EXPAND: restart; rk[0] recaptured, counter = 1, stays EXPAND.
- Key latency: key_load sampled at edge T -> key_ready high after edge T+10 (11 cycles, rk0..rk10).
- Data path: transfer when in_valid && in_ready.
  - Next edge: out_valid = 1, out_data = in_data ^ rk[in_round]. Latency 1, throughput 1 per cycle.
- No transfer: out_valid = 0; out_data holds its last value.
- in_valid while in_ready = 0: ignored, no output. Upstream must hold the data.
- key_load and a transfer in the same READY cycle: the transfer uses the old keys, key_ready drops next cycle.
- in_round > 10: out_valid = 1, out_err = 1, out_data = in_data unmodified. out_err = 0 on all valid-round outputs.
- Reset mid-expansion or mid-transfer: everything returns to reset values immediately; a key must be reloaded.
- Expansion step for word w0..w3 of previous key:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.

Decomposition:
- Package aes_pkg holds:
  - NUM_ROUNDS and state/key width constants
  - the 256-entry S-box as a function sbox(byte)
  - the rcon table as a function rcon(idx)
  - FSM state enum {IDLE, EXPAND, READY}
- Sub-module aes_key_expand_step: purely combinational (prev_key[127:0], rcon[7:0]) -> next_key[127:0], using four S-box lookups.
- The top module instantiates aes_key_expand_step once and holds the FSM, counter, key file and output register.

Test Plan:
- Reset: assert rst_n=0 mid-EXPAND -> key_ready=0, out_valid=0, out_data=0 immediately; after release, in_valid ignored until a key is loaded.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c loaded -> key_ready rises exactly 11 cycles later; rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- With that key ready, in_data=3243f6a8885a308d313198a2e0370734, in_round=0 -> next cycle out_valid=1, out_data=193de3bea0f4e22b9ac68d2ae9f84808.
- Back-to-back transfers with in_round 0..10 on consecutive cycles -> 11 consecutive out_valid pulses, each equal to in_data^rk[i]; in_round=12 -> out_err=1, out_data=in_data.
- key_load pulsed in EXPAND after 5 cycles with key 000102030405060708090a0b0c0d0e0f -> expansion restarts; key_ready 11 cycles after the second pulse; rk10=13111d7fe3944a17f307a78b4d2b30c5.
- key_load coincident with a READY transfer -> that output uses the old key; in_ready=0 next cycle, and in_valid is then ignored until key_ready returns.
